// File: rtl/mem_access_unit_if.sv
// Handshaked data-memory bus between the MEM-stage access unit and the memory.
// The master drives the request, the slave answers with MemReady/MemRData.
interface mem_access_unit_if;
  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemBE;
  logic        MemReady;
  logic [31:0] MemRData;

  modport master (
    output MemReq, MemWE, MemAddr, MemWData, MemBE,
    input  MemReady, MemRData
  );

  modport slave (
    input  MemReq, MemWE, MemAddr, MemWData, MemBE,
    output MemReady, MemRData
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns EX/MEM load/store controls into bus transactions,
// steering byte/half lanes, sign-extending loads and stalling until completion.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] ALUResultIN,
  input  logic [31:0]       readData2IN,
  input  logic [1:0]        MemReadIN,
  input  logic [1:0]        MemWriteIN,
  mem_access_unit_if.master bus,
  output logic [31:0]       LoadDataOUT,
  output logic              Stall,
  output logic              AccessErr
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        req_reg, req_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  be_reg, be_next;
  logic [31:0] load_reg, load_next;
  logic        err_reg, err_next;
  logic [1:0]  size_reg, size_next;
  logic [1:0]  lane_reg, lane_next;

  logic [31:0] addr32;
  logic [1:0]  op_size;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;
  logic        misaligned;
  logic        has_op;
  logic        illegal;
  logic        legal;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign addr32  = 32'(ALUResultIN);
  // A conflicting read+write still gets a size so it can be flagged rather than ignored.
  assign op_size = (MemReadIN != 2'b00) ? MemReadIN : MemWriteIN;
  assign has_op  = (op_size != 2'b00);
  assign illegal = has_op && (misaligned || ((MemReadIN != 2'b00) && (MemWriteIN != 2'b00)));
  assign legal   = has_op && !illegal;

  always_comb begin
    dec_be     = 4'b0000;
    dec_wdata  = 32'd0;
    misaligned = 1'b0;
    case (op_size)
      2'b01: begin
        dec_be     = 4'b1111;
        dec_wdata  = readData2IN;
        misaligned = (addr32[1:0] != 2'b00);
      end
      2'b10: begin
        dec_be     = addr32[1] ? 4'b1100 : 4'b0011;
        dec_wdata  = {2{readData2IN[15:0]}};
        misaligned = addr32[0];
      end
      2'b11: begin
        dec_be    = 4'b0001 << addr32[1:0];
        dec_wdata = {4{readData2IN[7:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the size/offset captured at launch, not the live inputs.
  assign byte_sel = bus.MemRData[{lane_reg, 3'b000} +: 8];
  assign half_sel = lane_reg[1] ? bus.MemRData[31:16] : bus.MemRData[15:0];

  always_comb begin
    load_ext = bus.MemRData;
    case (size_reg)
      2'b10:   load_ext = {{16{half_sel[15]}}, half_sel};
      2'b11:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      default: load_ext = bus.MemRData;
    endcase
  end

  assign Stall = !Reset && (((state_reg == IDLE) && legal) || (state_reg == ACCESS));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    be_next    = be_reg;
    load_next  = load_reg;
    err_next   = 1'b0;
    size_next  = size_reg;
    lane_next  = lane_reg;
    case (state_reg)
      IDLE: begin
        if (legal) begin
          req_next   = 1'b1;
          we_next    = (MemWriteIN != 2'b00);
          addr_next  = {addr32[31:2], 2'b00};
          wdata_next = dec_wdata;
          be_next    = dec_be;
          size_next  = op_size;
          lane_next  = addr32[1:0];
          cnt_next   = 8'd0;
          state_next = ACCESS;
        end else if (illegal) begin
          err_next = 1'b1;
        end
      end
      ACCESS: begin
        if (bus.MemReady) begin
          req_next   = 1'b0;
          state_next = DONE;
          if (!we_reg) begin
            load_next = load_ext;
          end
        end else if (cnt_reg == TO_LAST) begin
          req_next   = 1'b0;
          load_next  = 32'd0;
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      be_reg    <= 4'b0000;
      load_reg  <= 32'd0;
      err_reg   <= 1'b0;
      size_reg  <= 2'b00;
      lane_reg  <= 2'b00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      be_reg    <= be_next;
      load_reg  <= load_next;
      err_reg   <= err_next;
      size_reg  <= size_next;
      lane_reg  <= lane_next;
    end
  end

  assign bus.MemReq   = req_reg;
  assign bus.MemWE    = we_reg;
  assign bus.MemAddr  = addr_reg;
  assign bus.MemWData = wdata_reg;
  assign bus.MemBE    = be_reg;
  assign LoadDataOUT  = load_reg;
  assign AccessErr    = err_reg;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs. Turns the registered ALU result, store data and 2-bit MemRead/MemWrite controls into transactions on a handshaked data-memory bus.
- Handles byte/half/word lane steering and sign extension. Stalls the pipeline, holding EX/MEM and earlier stages, until each access completes.
- Flags misaligned or illegal accesses and timeouts.

Parameters:
- ADDR_W, 32, width of the ALU result used as the byte address.
- TIMEOUT, 16, maximum ACCESS cycles waiting for MemReady before the access is aborted (range 2..255).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ALUResultIN  in  ADDR_W  byte address from EX/MEM.
- readData2IN  in  32  store data from EX/MEM.
- MemReadIN  in  2  00 none, 01 word, 10 half, 11 byte.
- MemWriteIN  in  2  same encoding as MemReadIN.
- MemReady  in  1  memory completion strobe.
- MemRData  in  32  memory read word; valid when MemReady=1.
- MemReq  out  1  bus request, registered.
- MemWE  out  1  1 = write, registered.
- MemAddr  out  32  word-aligned address ({ALUResultIN[31:2],2'b00}), registered.
- MemWData  out  32  lane-replicated store data, registered.
- MemBE  out  4  byte enables, registered.
- LoadDataOUT  out  32  sign-extended load result, registered.
- Stall  out  1  combinational; holds the upstream pipeline.
- AccessErr  out  1  one-cycle error pulse, registered.

Behaviour:
- Reset (async, immediate): state=IDLE, timeout counter=0. All registered outputs are 0, so MemReq drops mid-access. Stall=0.
- Little-endian lanes:
  - Byte: lane = addr[1:0] (lane 0 = bits 7:0); BE = 1<<addr[1:0]; WData = {4{data[7:0]}}.
  - Half: addr[1]=0 selects bits 15:0, BE=0011; addr[1]=1 selects bits 31:16, BE=1100; WData = {2{data[15:0]}}.
  - Word: BE=1111.
- Loads: the selected byte or half is sign-extended to 32 bits.
- Legality checks:
  - Half access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]!=0 is misaligned.
  - MemReadIN!=0 and MemWriteIN!=0 together is illegal.
  - Result for any of these: AccessErr pulses 1 cycle, no bus request, Stall=0, LoadDataOUT unchanged.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If a legal operation is present: Stall=1 (combinational, same cycle). Next edge: MemReq=1, MemWE, MemAddr, MemBE and MemWData loaded; counter=0; state=ACCESS.
  - If no operation is present: Stall=0 and the state holds.
- ACCESS:
  - Stall=1; request outputs are held stable.
  - MemReady=1: next edge MemReq=0. For a read, LoadDataOUT is loaded from the extended MemRData. State=DONE.
  - MemReady=0: counter increments. When the counter reaches TIMEOUT-1 with MemReady still 0: next edge MemReq=0, LoadDataOUT=0, AccessErr pulse, state=DONE.
  - MemReady is ignored outside ACCESS.
- DONE:
  - Stall=0, so EX/MEM advances at this edge. Next state is unconditionally IDLE; the same operation is never re-issued.
  - LoadDataOUT holds its value until the next load completes.
- Latency: with MemReady in the first ACCESS cycle, 3 cycles from operation presentation to pipeline release (IDLE, ACCESS, DONE). Each further MemReady wait adds one cycle.
- Back-to-back operations: the next operation is detected in the IDLE cycle following DONE.
- Reset during ACCESS: the request is aborted immediately, no AccessErr, and the operation is not retried.

Test Plan:
- Word store: addr 0x100, data 0xDEADBEEF, MemWriteIN=01, MemReady after 2 cycles -> MemReq for 3 cycles, MemWE=1, MemAddr=0x100, MemBE=1111, MemWData=0xDEADBEEF, Stall high 4 cycles.
- Byte load sign extend: addr 0x203, MemReadIN=11, MemRData=0x80FFFFFF, immediate ready -> MemAddr=0x200, BE=1000, LoadDataOUT=0xFFFFFF80, Stall high 2 cycles.
- Half load upper half: addr 0x42, MemReadIN=10, MemRData=0x7ABC1234 -> BE=1100, LoadDataOUT=0x00007ABC. Half store at the same addr with data 0x0000BEEF -> MemWData=0xBEEFBEEF.
- Misaligned and illegal: word read at 0x101 -> AccessErr 1 cycle, MemReq never asserted, Stall=0. MemReadIN=01 with MemWriteIN=01 -> same result.
- Timeout: word read, MemReady held 0 -> MemReq high exactly TIMEOUT cycles (16), then AccessErr pulse, LoadDataOUT=0, Stall released in DONE.
- Reset mid-access: Reset asserted in the 3rd ACCESS cycle -> MemReq, Stall and AccessErr go 0 asynchronously. After release, state is IDLE and a new legal operation starts normally.
